hc_reduce_n: RTL

Consumer of the element-wise h·C product: reduces `hC_flat` (B·H·P·N fp16 terms) over the state dimension N to produce `y[b,h,p] = Σ_n hC[b,h,p,n]`. It sits directly after the h·C multiply stage in the Mamba-2 SSM datapath and feeds the D-skip / output stage. The block uses PAR pipelined fp16 adders with loop-carried accumulation across N passes.

---
 rtl/hc_reduce_n_pkg.sv | 93 +++++++++
 rtl/hc_reduce_n_if.sv | 15 +
 rtl/hc_reduce_n_fp16_add_wrapper.sv | 32 +++
 rtl/hc_reduce_n.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/hc_reduce_n_pkg.sv
// Shared definitions for the hC reduction block: fp16 constants, controller
// states, pass-timing derivations and a combinational IEEE fp16 adder.
package hc_reduce_n_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int calcCh(input int g, input int par);
        return (g + par - 1) / par;
    endfunction

    function automatic int calcT(input int ch, input int aLat);
        return (ch > aLat) ? ch : aLat + 1;
    endfunction

    function automatic int calcL(input int n, input int t, input int aLat);
        return 2 + (n - 1) * t + aLat;
    endfunction

    // Round-to-nearest-even fp16 add using guard/round/sticky bits below the LSB.
    function automatic logic [15:0] fp16Add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [4:0]  ex;
        logic [4:0]  ey;
        logic [14:0] mx;
        logic [14:0] my;
        logic [14:0] s;
        logic [11:0] m;
        logic        sticky;
        logic        roundUp;
        int          d;
        int          e;
        if (a[14:10] == 5'h1F && a[9:0] != 10'h0) return FP16_QNAN;
        if (b[14:10] == 5'h1F && b[9:0] != 10'h0) return FP16_QNAN;
        if (a[14:10] == 5'h1F) begin
            if (b[14:10] == 5'h1F && a[15] != b[15]) return FP16_QNAN;
            return a;
        end
        if (b[14:10] == 5'h1F) return b;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = (x[14:10] == 5'h0) ? 5'd1 : x[14:10];
        ey = (y[14:10] == 5'h0) ? 5'd1 : y[14:10];
        mx = {1'b0, x[14:10] != 5'h0, x[9:0], 3'b000};
        my = {1'b0, y[14:10] != 5'h0, y[9:0], 3'b000};
        d = int'(ex) - int'(ey);
        sticky = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i < d) begin
                sticky = sticky | my[0];
                my = my >> 1;
            end
        end
        my[0] = my[0] | sticky;
        s = (x[15] == y[15]) ? mx + my : mx - my;
        if (s == 15'h0) return {x[15] & y[15], 15'h0};
        e = int'(ex);
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (!s[13] && e > 1) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        roundUp = s[2] & (s[1] | s[0] | s[3]);
        m = {1'b0, s[13:3]} + {11'h0, roundUp};
        if (m[11]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 31) return {x[15], 5'h1F, 10'h0};
        return {x[15], m[10] ? e[4:0] : 5'd0, m[9:0]};
    endfunction

endpackage

// File: rtl/hc_reduce_n_if.sv
// Request/response bundle between the h*C multiply stage, the reducer and
// the output stage.
interface hc_reduce_n_if #(
    parameter int G  = 16,
    parameter int N  = 4,
    parameter int DW = 16
);
    logic              start;
    logic [G*N*DW-1:0] hC_flat;
    logic [G*DW-1:0]   y_flat;
    logic              done;

    modport master (output start, output hC_flat, input y_flat, input done);
    modport slave  (input start, input hC_flat, output y_flat, output done);
endinterface

// File: rtl/hc_reduce_n_fp16_add_wrapper.sv
// Fixed-latency fp16 adder lane; the data path carries no reset, so valid_out
// is meaningless until A_LAT cycles of defined valid_in have been seen.
module fp16_add_wrapper
    import hc_reduce_n_pkg::*;
#(
    parameter int DW    = 16,
    parameter int A_LAT = 6
) (
    input  logic          clk,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          valid_in,
    output logic [DW-1:0] result,
    output logic          valid_out
);

    logic [DW-1:0] res_q [A_LAT];
    logic          val_q [A_LAT];

    always_ff @(posedge clk) begin
        res_q[0] <= fp16Add(a, b);
        val_q[0] <= valid_in;
        for (int s = 1; s < A_LAT; s++) begin
            res_q[s] <= res_q[s-1];
            val_q[s] <= val_q[s-1];
        end
    end

    assign result    = res_q[A_LAT-1];
    assign valid_out = val_q[A_LAT-1];

endmodule

// File: rtl/hc_reduce_n.sv
// Reduces B*H*P groups of N fp16 terms to one sum per group using PAR
// pipelined adder lanes and a loop-carried accumulator per group.
module hc_reduce_n
    import hc_reduce_n_pkg::*;
#(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int A_LAT = 6,
    parameter int PAR   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    hc_reduce_n_if.slave bus
);

    localparam int G  = B * H * P;
    localparam int CH = calcCh(G, PAR);
    localparam int T  = calcT(CH, A_LAT);
    localparam int CW = $clog2(T + A_LAT + 1);
    localparam int PW = $clog2(N + 1);
    localparam int TW = $clog2(G + 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   pass_q;
    logic [DW-1:0]   acc_q [G];
    logic [G*DW-1:0] y_q;
    logic            done_q;

    logic [DW-1:0]   laneA   [PAR];
    logic [DW-1:0]   laneB   [PAR];
    logic [DW-1:0]   laneRes [PAR];
    logic [TW-1:0]   laneTag [PAR];
    logic [PAR-1:0]  laneValid;

    logic            tagV_q   [PAR][A_LAT];
    logic [TW-1:0]   tagIdx_q [PAR][A_LAT];

    // Group g rides lane g%PAR in issue cycle g/PAR; unused lanes stay invalid.
    always_comb begin
        laneValid = '0;
        for (int i = 0; i < PAR; i++) begin
            laneA[i]   = '0;
            laneB[i]   = '0;
            laneTag[i] = '0;
        end
        if (state_q == ST_ACCUM) begin
            for (int g = 0; g < G; g++) begin
                if (cnt_q == CW'(g / PAR)) begin
                    laneValid[g % PAR] = 1'b1;
                    laneTag[g % PAR]   = TW'(g);
                    laneA[g % PAR]     = acc_q[g];
                    for (int n = 1; n < N; n++) begin
                        if (pass_q == PW'(n)) laneB[g % PAR] = bus.hC_flat[(g*N+n)*DW +: DW];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < PAR; i++) begin : gLane
        fp16_add_wrapper #(.DW(DW), .A_LAT(A_LAT)) uAdd (
            .clk       (clk),
            .a         (laneA[i]),
            .b         (laneB[i]),
            .valid_in  (laneValid[i]),
            .result    (laneRes[i]),
            .valid_out ()
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAR; i++) begin
                for (int s = 0; s < A_LAT; s++) begin
                    tagV_q[i][s]   <= 1'b0;
                    tagIdx_q[i][s] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < PAR; i++) begin
                tagV_q[i][0]   <= laneValid[i];
                tagIdx_q[i][0] <= laneTag[i];
                for (int s = 1; s < A_LAT; s++) begin
                    tagV_q[i][s]   <= tagV_q[i][s-1];
                    tagIdx_q[i][s] <= tagIdx_q[i][s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pass_q  <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            for (int g = 0; g < G; g++) acc_q[g] <= FP16_ZERO;
        end else begin
            done_q <= 1'b0;
            for (int i = 0; i < PAR; i++) begin
                for (int g = 0; g < G; g++) begin
                    if (tagV_q[i][A_LAT-1] && tagIdx_q[i][A_LAT-1] == TW'(g)) acc_q[g] <= laneRes[i];
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    for (int g = 0; g < G; g++) acc_q[g] <= bus.hC_flat[(g*N)*DW +: DW];
                    cnt_q   <= '0;
                    pass_q  <= PW'(1);
                    state_q <= (N == 1) ? ST_DRAIN : ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (cnt_q == CW'(T - 1)) begin
                        cnt_q <= '0;
                        if (pass_q == PW'(N - 1)) state_q <= ST_DRAIN;
                        else pass_q <= pass_q + PW'(1);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == CW'(A_LAT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    for (int g = 0; g < G; g++) y_q[g*DW +: DW] <= acc_q[g];
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.y_flat = y_q;
    assign bus.done   = done_q;

endmodule
